ahb_burst_ctrl: RTL and testbench

AHB_BURST_CTRL -- requirements
Module: ahb_burst_ctrl

---
 rtl/ahb_burst_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_ahb_burst_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_ctrl.sv
// AHB burst master sequencer: accepts one burst command and drives the AHB address phase.
// Define AHB_BURST_CTRL_BUSY_EN to let cmd_hold insert BUSY transfers between beats.
module ahb_burst_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [2:0]        cmd_size,
    input  logic              cmd_write,
    input  logic [4:0]        cmd_len,
    input  logic              cmd_hold,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HBURST,
    output logic [2:0]        HSIZE,
    output logic              HWRITE,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;
`ifdef AHB_BURST_CTRL_BUSY_EN
    localparam logic [1:0] TR_BUSY   = 2'd1;
`endif

    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR   = 3'd1;
    localparam logic [2:0] B_WRAP4  = 3'd2;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_WRAP8  = 3'd4;
    localparam logic [2:0] B_INCR8  = 3'd5;
    localparam logic [2:0] B_WRAP16 = 3'd6;
    localparam logic [2:0] B_INCR16 = 3'd7;

    localparam logic [2:0] MAX_SIZE = (DATA_W >= 32) ? 3'd2 : (DATA_W >= 16) ? 3'd1 : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NSEQ  = 3'd1,
        S_SEQB  = 3'd2,
        S_LASTD = 3'd3,
`ifdef AHB_BURST_CTRL_BUSY_EN
        S_BUSYB = 3'd5,
`endif
        S_ERRW  = 3'd4
    } state_t;

    state_t      r_state;
    logic [4:0]  r_beats;
    logic        r_rej;

    function automatic logic [4:0] f_beats(input logic [2:0] burst, input logic [4:0] len);
        case (burst)
            B_SINGLE:          f_beats = 5'd1;
            B_INCR:            f_beats = (len == 5'd0 || len > 5'd16) ? 5'd16 : len;
            B_WRAP4, B_INCR4:  f_beats = 5'd4;
            B_WRAP8, B_INCR8:  f_beats = 5'd8;
            B_WRAP16, B_INCR16: f_beats = 5'd16;
            default:           f_beats = 5'd16;
        endcase
    endfunction

    // Command legality, evaluated against the request itself.
    logic [4:0]        w_cmd_beats;
    logic [ADDR_W-1:0] w_cmd_step;
    logic [12:0]       w_cmd_span;
    logic              w_cmd_wrap;
    logic              w_cmd_fixed;
    logic              w_reject;

    assign w_cmd_beats = f_beats(cmd_burst, cmd_len);
    assign w_cmd_step  = ADDR_W'(1) << cmd_size;
    assign w_cmd_span  = 13'(w_cmd_beats) << cmd_size;
    assign w_cmd_wrap  = (cmd_burst != B_SINGLE) && !cmd_burst[0];
    assign w_cmd_fixed = (cmd_burst != B_INCR) && cmd_burst[0];
    assign w_reject    = (cmd_size > MAX_SIZE)
                      || (w_cmd_wrap && |(cmd_addr & (w_cmd_step - ADDR_W'(1))))
                      || (w_cmd_fixed && ((13'(cmd_addr[9:0]) + w_cmd_span) > 13'd1024));

    // Next-beat address generation from the live address phase.
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_wrap_mask;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_next;
    logic              w_page_cross;

    assign w_step       = ADDR_W'(1) << HSIZE;
    assign w_wrap_mask  = (ADDR_W'(f_beats(HBURST, 5'd16)) << HSIZE) - ADDR_W'(1);
    assign w_incr       = HADDR + w_step;
    assign w_next       = ((HBURST != B_SINGLE) && !HBURST[0])
                        ? ((HADDR & ~w_wrap_mask) | (w_incr & w_wrap_mask)) : w_incr;
    assign w_page_cross = (HBURST == B_INCR) && (w_incr[ADDR_W-1:10] != HADDR[ADDR_W-1:10]);

`ifndef AHB_BURST_CTRL_BUSY_EN
    logic w_unused_hold;
    assign w_unused_hold = cmd_hold;
`endif

    logic w_active;
    assign w_active = (r_state != S_IDLE) && (r_state != S_ERRW);

    // Completion flags qualify on the slave's HREADY in the very cycle the data phase ends.
    assign done = (r_state == S_LASTD) && HREADY && !HRESP;
    assign err  = r_rej || ((r_state == S_ERRW) && HREADY) || (w_active && HREADY && HRESP);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= S_IDLE;
            r_beats   <= 5'd0;
            r_rej     <= 1'b0;
            cmd_ready <= 1'b0;
            HADDR     <= '0;
            HTRANS    <= TR_IDLE;
            HBURST    <= B_SINGLE;
            HSIZE     <= 3'd0;
            HWRITE    <= 1'b0;
        end else begin
            r_rej <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        if (w_reject) begin
                            r_rej <= 1'b1;
                        end else begin
                            r_state   <= S_NSEQ;
                            cmd_ready <= 1'b0;
                            HTRANS    <= TR_NONSEQ;
                            HADDR     <= cmd_addr;
                            HBURST    <= cmd_burst;
                            HSIZE     <= cmd_size;
                            HWRITE    <= cmd_write;
                            r_beats   <= w_cmd_beats;
                        end
                    end
                end
                S_ERRW: begin
                    if (HREADY) begin
                        r_state   <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    if (HRESP) begin
                        HTRANS  <= TR_IDLE;
                        r_beats <= 5'd0;
                        if (HREADY) begin
                            r_state   <= S_IDLE;
                            cmd_ready <= 1'b1;
                        end else begin
                            r_state <= S_ERRW;
                        end
                    end else if (HREADY) begin
                        if (r_state == S_LASTD) begin
                            r_state   <= S_IDLE;
                            cmd_ready <= 1'b1;
`ifdef AHB_BURST_CTRL_BUSY_EN
                        end else if (r_state == S_BUSYB) begin
                            if (!cmd_hold) begin
                                HTRANS  <= TR_SEQ;
                                r_state <= S_SEQB;
                            end
`endif
                        end else begin
                            r_beats <= r_beats - 5'd1;
                            if (r_beats == 5'd1) begin
                                HTRANS  <= TR_IDLE;
                                r_state <= S_LASTD;
                            end else begin
                                HADDR <= w_next;
                                if (w_page_cross) begin
                                    HTRANS  <= TR_NONSEQ;
                                    HBURST  <= B_INCR;
                                    r_state <= S_NSEQ;
`ifdef AHB_BURST_CTRL_BUSY_EN
                                end else if (cmd_hold) begin
                                    HTRANS  <= TR_BUSY;
                                    r_state <= S_BUSYB;
`endif
                                end else begin
                                    HTRANS  <= TR_SEQ;
                                    r_state <= S_SEQB;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_burst_ctrl.sv
// Self-checking bench for ahb_burst_ctrl: directed scenarios plus random bursts against an address-list model.
module tb_ahb_burst_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_burst = '0;
    logic [2:0]  cmd_size = '0;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_len = '0;
    logic        cmd_hold = 1'b0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        done;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_addr[$];
    logic [1:0]  exp_trans[$];

    ahb_burst_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_write(cmd_write),
        .cmd_len(cmd_len), .cmd_hold(cmd_hold), .HREADY(HREADY), .HRESP(HRESP),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .done(done), .err(err)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model_beats(input int unsigned b, input int unsigned l);
        case (b)
            0: return 1;
            1: return (l == 0 || l > 16) ? 16 : l;
            2, 3: return 4;
            4, 5: return 8;
            default: return 16;
        endcase
    endfunction

    // Waits for cmd_ready, presents one command for a single cycle and returns in the
    // cycle after acceptance with HREADY=1, HRESP=0, outputs settled.
    task automatic issue(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                         input logic w, input logic [4:0] l);
        int k = 0;
        @(negedge HCLK);
        while (!cmd_ready && k < 20) begin
            @(negedge HCLK);
            k++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_burst = b; cmd_size = s; cmd_write = w; cmd_len = l;
        @(negedge HCLK);
        cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0; cmd_hold = 1'b0;
        #1;
    endtask

    task automatic run_burst(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                             input logic w, input logic [4:0] l, input bit rnd);
        int unsigned n    = model_beats(b, l);
        int unsigned step = 1 << s;
        int unsigned span;
        int unsigned base;
        int unsigned x;
        bit wrap  = (b == 2 || b == 4 || b == 6);
        bit fixed = (b == 3 || b == 5 || b == 7);
        bit rej   = (s > 2) || (wrap && (a % step) != 0) || (fixed && ((a % 1024) + n * step > 1024));
        int idx = 0;
        int cyc = 0;
        bit seen = 0;
        exp_addr.delete();
        exp_trans.delete();
        for (int i = 0; i < int'(n); i++) begin
            if (wrap) begin
                span = n * step;
                base = (a / span) * span;
                x = base + (a - base + i * step) % span;
            end else begin
                x = a + i * step;
            end
            exp_addr.push_back(x);
            exp_trans.push_back((i == 0 || (b == 1 && x % 1024 == 0)) ? 2'd2 : 2'd3);
        end
        issue(a, b, s, w, l);
        if (rej) begin
            chk("rej_err", err, 1);
            chk("rej_done", done, 0);
            chk("rej_htrans", HTRANS, 0);
            @(negedge HCLK); #1;
            chk("rej_err_clear", err, 0);
            chk("rej_htrans_after", HTRANS, 0);
            return;
        end
        chk("acc_ready_low", cmd_ready, 0);
        if (rnd) begin
            HREADY = ($urandom_range(0, 3) != 0);
            cmd_hold = ($urandom_range(0, 3) == 0);
            #1;
        end
        while (!seen && cyc < 400) begin
            if (err) chk("unexpected_err", err, 0);
            if (done) begin
                seen = 1;
                chk("done_beats", idx, n);
                if (!rnd) chk("done_cycle", cyc, n);
            end else if (HTRANS == 2'd1) begin
`ifdef AHB_BURST_CTRL_BUSY_EN
                if (idx > 0 && idx < int'(n)) chk("busy_addr", HADDR, exp_addr[idx]);
                else chk("busy_position", idx, 1);
`else
                chk("busy_forbidden", HTRANS, 2'd3);
`endif
            end else if (HTRANS[1] && HREADY) begin
                if (idx >= int'(n)) begin
                    chk("extra_beat", idx, n - 1);
                end else begin
                    chk("beat_addr", HADDR, exp_addr[idx]);
                    chk("beat_trans", HTRANS, exp_trans[idx]);
                    chk("beat_burst", HBURST, b);
                    chk("beat_size", HSIZE, s);
                    chk("beat_write", HWRITE, w);
                    if (!rnd) chk("beat_cycle", cyc, idx);
                end
                idx++;
            end
            if (!seen) begin
                @(negedge HCLK);
                HREADY = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                cmd_hold = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
                #1;
                cyc++;
            end
        end
        chk("done_seen", seen, 1);
        @(negedge HCLK);
        HREADY = 1'b1; cmd_hold = 1'b0;
        #1;
        chk("post_done_low", done, 0);
        chk("post_ready", cmd_ready, 1);
        chk("post_htrans", HTRANS, 0);
    endtask

    initial begin
        int unsigned a;
        int unsigned s;
        int unsigned b;
        int unsigned se;

        // Reset values
        @(negedge HCLK); @(negedge HCLK); #1;
        chk("rst_htrans", HTRANS, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hburst", HBURST, 0);
        chk("rst_hsize", HSIZE, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        HRESETn = 1'b1;
        #1;
        chk("rst_ready_no_edge", cmd_ready, 0);
        @(negedge HCLK); #1;
        chk("rst_ready_rise", cmd_ready, 1);

        // Directed bursts with HREADY held high
        run_burst(32'h100, 3'd3, 3'd2, 1'b1, 5'd0, 0);
        run_burst(32'h38,  3'd2, 3'd2, 1'b0, 5'd0, 0);
        run_burst(32'h3FC, 3'd1, 3'd1, 1'b1, 5'd4, 0);
        run_burst(32'h3C0, 3'd7, 3'd2, 1'b0, 5'd0, 0);
        run_burst(32'h3F0, 3'd7, 3'd2, 1'b0, 5'd0, 0);
        run_burst(32'h3A,  3'd2, 3'd2, 1'b0, 5'd0, 0);
        run_burst(32'h20,  3'd1, 3'd3, 1'b0, 5'd4, 0);
        run_burst(32'h7C0, 3'd1, 3'd2, 1'b1, 5'd0, 0);
        run_burst(32'h500, 3'd1, 3'd0, 1'b0, 5'd20, 0);
        run_burst(32'h44,  3'd0, 3'd2, 1'b1, 5'd9, 0);
        run_burst(32'h3E,  3'd6, 3'd1, 1'b0, 5'd0, 0);

        // Two-cycle ERROR on the third beat of an INCR8
        issue(32'h10, 3'd5, 3'd2, 1'b1, 5'd0);
        @(negedge HCLK); #1;
        @(negedge HCLK); #1;
        chk("e_beat3_addr", HADDR, 32'h18);
        HREADY = 1'b0; HRESP = 1'b1; #1;
        chk("e_first_err", err, 0);
        chk("e_first_done", done, 0);
        @(negedge HCLK);
        HREADY = 1'b1; HRESP = 1'b1; #1;
        chk("e_htrans_idle", HTRANS, 0);
        chk("e_err_pulse", err, 1);
        chk("e_no_done", done, 0);
        @(negedge HCLK);
        HRESP = 1'b0; #1;
        chk("e_ready", cmd_ready, 1);
        chk("e_err_clear", err, 0);
        chk("e_done_after", done, 0);
        chk("e_htrans_after", HTRANS, 0);

        // ERROR in the same cycle as last-beat acceptance
        issue(32'h200, 3'd3, 3'd2, 1'b0, 5'd0);
        @(negedge HCLK); #1;
        @(negedge HCLK); #1;
        @(negedge HCLK); #1;
        chk("el_last_addr", HADDR, 32'h20C);
        HRESP = 1'b1; #1;
        chk("el_err", err, 1);
        chk("el_no_done", done, 0);
        @(negedge HCLK);
        HRESP = 1'b0; #1;
        chk("el_htrans_idle", HTRANS, 0);
        chk("el_done_after", done, 0);
        chk("el_err_after", err, 0);
        chk("el_ready", cmd_ready, 1);

        // cmd_hold after beat 2 of INCR4 from 0x0
        issue(32'h0, 3'd3, 3'd2, 1'b1, 5'd0);
        @(negedge HCLK);
        cmd_hold = 1'b1; #1;
        chk("h_beat2_addr", HADDR, 32'h4);
        @(negedge HCLK); #1;
`ifdef AHB_BURST_CTRL_BUSY_EN
        chk("h_busy1_trans", HTRANS, 2'd1);
        chk("h_busy1_addr", HADDR, 32'h8);
        @(negedge HCLK);
        cmd_hold = 1'b0; #1;
        chk("h_busy2_trans", HTRANS, 2'd1);
        chk("h_busy2_addr", HADDR, 32'h8);
        @(negedge HCLK); #1;
`else
        cmd_hold = 1'b0;
`endif
        chk("h_seq8_trans", HTRANS, 2'd3);
        chk("h_seq8_addr", HADDR, 32'h8);
        @(negedge HCLK); #1;
        chk("h_seqc_trans", HTRANS, 2'd3);
        chk("h_seqc_addr", HADDR, 32'hC);
        @(negedge HCLK); #1;
        chk("h_done", done, 1);
        chk("h_err", err, 0);

        // Reset in the middle of a burst
        issue(32'h40, 3'd5, 3'd2, 1'b0, 5'd0);
        @(negedge HCLK); #1;
        HRESETn = 1'b0; #1;
        chk("mr_htrans", HTRANS, 0);
        chk("mr_haddr", HADDR, 0);
        chk("mr_ready", cmd_ready, 0);
        chk("mr_done", done, 0);
        chk("mr_err", err, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK); #1;
        chk("mr_ready_rise", cmd_ready, 1);
        chk("mr_done_after", done, 0);
        chk("mr_err_after", err, 0);
        chk("mr_htrans_after", HTRANS, 0);

        // Random bursts with random wait states and hold requests
        for (int t = 0; t < 40; t++) begin
            s  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            se = (s > 2) ? 2 : s;
            b  = $urandom_range(0, 7);
            a  = $urandom_range(0, 3) * 1024
               + (($urandom_range(0, 1) != 0) ? $urandom_range(0, 1023) : 1024 - $urandom_range(1, 64));
            a  = a & ~((32'd1 << se) - 1);
            if ((b == 2 || b == 4 || b == 6) && $urandom_range(0, 5) == 0) a = a | 1;
            run_burst(a, 3'(b), 3'(s), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
